// File: rtl/wb_stream_fifo.sv
// Synchronous FIFO bridging a pipelined Wishbone device port (single-beat writes)
// to a pipelined Wishbone controller port that replays stored words in order.
module wb_stream_fifo #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned ADDR_WIDTH      = 4,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned ALMOST_FULL     = (2 ** ADDR_WIDTH) - 2,
   parameter int unsigned ALMOST_EMPTY    = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  s_cyc_i,
   input  logic                  s_stb_i,
   input  logic [DATA_WIDTH-1:0] s_dat_i,
   output logic                  s_stall_o,
   output logic                  s_ack_o,
   output logic                  m_cyc_o,
   output logic                  m_stb_o,
   output logic [DATA_WIDTH-1:0] m_dat_o,
   input  logic                  m_stall_i,
   input  logic                  m_ack_i,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic                  proto_err_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned CW    = ADDR_WIDTH + 1;
   localparam int unsigned OW    = 4;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_d;
   logic [OW-1:0]         outs_q;
   logic [OW-1:0]         outs_d;
   logic                  full_q;
   logic                  empty_q;
   logic                  almost_full_q;
   logic                  almost_empty_q;
   logic                  s_ack_q;
   logic                  proto_err_q;
   logic                  push;
   logic                  pop;
   logic                  ack_hit;

   // Stall looks only at the registered full flag, so no path from m_stall_i.
   assign push      = s_cyc_i && s_stb_i && !full_q;
   assign s_stall_o = s_cyc_i && s_stb_i && full_q;

   assign m_stb_o = !empty_q && (outs_q < OW'(MAX_OUTSTANDING));
   assign pop     = m_stb_o && !m_stall_i;
   assign m_cyc_o = m_stb_o || (outs_q != '0);
   assign m_dat_o = mem[rd_ptr_q];

   // An ack in the same cycle as a pop retires against that beat.
   assign ack_hit = m_ack_i && ((outs_q != '0) || pop);

   always_comb begin
      count_d = count_q;
      outs_d  = outs_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CW'(1);
      end
      if (pop && !ack_hit) begin
         outs_d = outs_q + OW'(1);
      end else if (!pop && ack_hit) begin
         outs_d = outs_q - OW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_q] <= s_dat_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         outs_q         <= '0;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= (ALMOST_FULL == 0);
         almost_empty_q <= 1'b1;
         s_ack_q        <= 1'b0;
         proto_err_q    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
         end
         count_q        <= count_d;
         outs_q         <= outs_d;
         full_q         <= (count_d == CW'(DEPTH));
         empty_q        <= (count_d == '0);
         almost_full_q  <= (32'(count_d) >= ALMOST_FULL);
         almost_empty_q <= (32'(count_d) <= ALMOST_EMPTY);
         s_ack_q        <= push;
         if (m_ack_i && !ack_hit) begin
            proto_err_q <= 1'b1;
         end
      end
   end

   assign count_o        = count_q;
   assign full_o         = full_q;
   assign empty_o        = empty_q;
   assign almost_full_o  = almost_full_q;
   assign almost_empty_o = almost_empty_q;
   assign s_ack_o        = s_ack_q;
   assign proto_err_o    = proto_err_q;

endmodule
